fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory address from the PC and
// registers the decoded instruction fields into the IF/ID entry for the decoder.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [8:0]  imem_data,
  output logic [3:0]  opcode,
  output logic        imm_flag,
  output logic [3:0]  operand,
  output logic [1:0]  format,
  output logic        if_valid,
  output logic [7:0]  if_pc,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 16;
  localparam logic [OP_W-1:0] OP_HALT = 4'hE;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [OP_W-1:0]   dec_opcode;
  logic [1:0]        dec_format;

  assign imem_addr  = pc;
  assign dec_opcode = imem_data[8:5];

  // Instruction format class from the opcode; unlisted opcodes fall in class 0.
  always_comb begin
    dec_format = 2'b00;
    case (dec_opcode)
      4'h2, 4'hA, 4'hB, 4'hC, 4'hF: dec_format = 2'b01;
      4'h0, 4'h3:                   dec_format = 2'b10;
      4'h1, 4'h4, 4'hE:             dec_format = 2'b11;
      default:                      dec_format = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      opcode      <= '0;
      imm_flag    <= 1'b0;
      operand     <= '0;
      format      <= '0;
      if_pc       <= '0;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_valid <= 1'b0;
          halted   <= 1'b0;
          pc       <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (redirect) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            opcode   <= dec_opcode;
            imm_flag <= imem_data[4];
            operand  <= imem_data[3:0];
            format   <= dec_format;
            if_pc    <= pc;
            if_valid <= 1'b1;
            if (fetch_count != {CNT_W{1'b1}}) fetch_count <= fetch_count + CNT_W'(1);
            // HALT is delivered to decode but the PC parks on its address.
            if (dec_opcode == OP_HALT) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              pc <= pc + PC_W'(1);
            end
          end
        end
        HALTED: begin
          if_valid <= 1'b0;
          if (redirect) begin
            pc     <= redirect_pc;
            state  <= RUN;
            halted <= 1'b0;
          end else if (start) begin
            pc     <= '0;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          if_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule
